// File: rtl/retry_inorder_end.sv
// -----------------------------------------------------------------------------
// retry_inorder_end
//
// Receiving end of the in-order retry pair. Sits at the output of a pipelined
// combinational datapath whose entry is driven by the in-order retry start
// block. Each result's ID is compared with the next expected in-order ID.
// In-order, fault-free results go downstream. Faulty or out-of-order results
// go back through the retry port. Upstream intake stays locked until the
// recovery completes.
//
// Handshake rule (every valid/ready pair here): a beat transfers on a rising
// clock edge where valid and ready are both 1. A source holding valid=1 keeps
// its payload stable until ready=1. This block holds no payload storage.
// Every output is a combinational function of the inputs and the two state
// registers.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   data_i, id_i         result from the datapath and the ID it carries
//   needs_retry_i        result flagged faulty by an upstream checker
//   valid_i / ready_o    upstream handshake
//   data_o               result forwarded downstream (equals data_i)
//   valid_o / ready_i    downstream handshake
//   retry_valid_o        element is being sent back for retry
//   retry_id_o           ID of the element being sent back
//   retry_lock_o         hold off new intake at the start block
//   retry_ready_i        start block accepts the retry element
//   retry_id_feedback_i  ID the start side will give the retried element
//   dbg_mode_o           current mode (0 = NORMAL, 1 = RECOVER)
//   dbg_expected_id_o    next expected in-order ID
// -----------------------------------------------------------------------------
module retry_inorder_end #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IDSize    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 needs_retry_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 retry_valid_o,
  output logic [IDSize-1:0]    retry_id_o,
  output logic                 retry_lock_o,
  input  logic                 retry_ready_i,
  input  logic [IDSize-1:0]    retry_id_feedback_i,
  output logic                 dbg_mode_o,
  output logic [IDSize-1:0]    dbg_expected_id_o
);

  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_RECOVER = 1'b1
  } mode_e;

  mode_e             r_mode_q;
  mode_e             w_mode_d;
  logic [IDSize-1:0] r_expected_id_q;
  logic [IDSize-1:0] w_expected_id_d;

  logic w_match;
  logic w_pass;
  logic w_fail;

  // Parity increment: the low IDSize-1 bits are the sequence. The carry out
  // of the sequence toggles the parity MSB. That is exactly a full-width +1
  // modulo 2^IDSize, so it wraps the same way as the start counter.
  function automatic logic [IDSize-1:0] parity_inc(input logic [IDSize-1:0] id);
    return id + {{(IDSize-1){1'b0}}, 1'b1};
  endfunction

  // The compare covers the full ID, parity included. Each cycle exactly one
  // of pass/fail is set when valid_i is high.
  assign w_match = (id_i == r_expected_id_q);
  assign w_pass  = valid_i & w_match & ~needs_retry_i;
  assign w_fail  = valid_i & ~w_pass;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode_q        <= MODE_NORMAL;
      r_expected_id_q <= '0;
    end else begin
      r_mode_q        <= w_mode_d;
      r_expected_id_q <= w_expected_id_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_mode_d        = r_mode_q;
    w_expected_id_d = r_expected_id_q;
    case (r_mode_q)
      MODE_NORMAL: begin
        if (w_pass && ready_i) begin
          w_expected_id_d = parity_inc(r_expected_id_q);
        end else if (w_fail && retry_ready_i) begin
          // The retried element comes back with the ID that the start side
          // reports at this handshake, so expect that ID next.
          w_expected_id_d = retry_id_feedback_i;
          w_mode_d        = MODE_RECOVER;
        end
      end
      MODE_RECOVER: begin
        if (w_pass && ready_i) begin
          w_expected_id_d = parity_inc(r_expected_id_q);
          w_mode_d        = MODE_NORMAL;
        end else if (valid_i && w_match && needs_retry_i && retry_ready_i) begin
          // The expected element faulted again. It is re-issued under a new ID.
          w_expected_id_d = retry_id_feedback_i;
        end
        // A stale in-flight element (ID mismatch) is only bounced back.
        // It leaves the state unchanged.
      end
      default: begin
        w_mode_d        = MODE_NORMAL;
        w_expected_id_d = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    data_o        = data_i;
    valid_o       = w_pass;
    retry_valid_o = w_fail;
    retry_id_o    = id_i;
    ready_o       = 1'b0;
    if (w_pass) begin
      ready_o = ready_i;
    end else if (w_fail) begin
      ready_o = retry_ready_i;
    end
    // Combinational so that the start block sees the lock in the same cycle
    // as the first failure. The start block registers it.
    retry_lock_o      = (r_mode_q == MODE_RECOVER) | (w_fail & (r_mode_q == MODE_NORMAL));
    dbg_mode_o        = r_mode_q;
    dbg_expected_id_o = r_expected_id_q;
  end

endmodule
